// File: rtl/irrigation_scheduler_pkg.sv
// Shared types and sizing helpers for the irrigation pump/valve scheduler.
package irr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        OPEN,
        SWITCH,
        FAULT
    } sched_state_t;

    localparam int N_VALVES_DEF = 4;

    // A single-valve build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(N_VALVES_DEF);

endpackage

// File: rtl/irrigation_scheduler_rr_pick.sv
// Combinational round-robin search: first set request at ptr, ptr+1, ... wrapping.
module irr_rr_pick
    import irr_pkg::*;
#(
    parameter int N_VALVES = N_VALVES_DEF,
    parameter int IDX_W    = idx_width(N_VALVES)
) (
    input  logic [N_VALVES-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);

    always_comb begin : search
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_VALVES; i++) begin
            j = (int'(ptr) + i) % N_VALVES;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Time-shares one pump between N_VALVES valves: prime, round-robin bounded slots,
// closed-valve drain gaps, and a latched FAULT on loss of water.
module irrigation_scheduler
    import irr_pkg::*;
#(
    parameter int N_VALVES     = N_VALVES_DEF,
    parameter int PRIME_CYCLES = 4,
    parameter int SLOT_CYCLES  = 16,
    parameter int DRAIN_CYCLES = 2,
    localparam int IDX_W       = idx_width(N_VALVES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_VALVES-1:0] req,
    input  logic                lvl_ok,
    output logic                pump_on,
    output logic [N_VALVES-1:0] valve,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic [N_VALVES-1:0] done,
    output logic                err,
    output sched_state_t        state_dbg,
    output logic [IDX_W-1:0]    ptr_dbg
);

    localparam int CNT_MAX_PS = (PRIME_CYCLES > SLOT_CYCLES) ? PRIME_CYCLES : SLOT_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_PS > DRAIN_CYCLES) ? CNT_MAX_PS : DRAIN_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_VALVES - 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    irr_rr_pick #(
        .N_VALVES (N_VALVES),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign state_dbg = state;
    assign ptr_dbg   = ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pump_on <= 1'b0;
            valve   <= '0;
            gnt_idx <= '0;
            done    <= '0;
            err     <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (lvl_ok && |req) begin
                        state   <= PRIME;
                        pump_on <= 1'b1;
                        cnt     <= '0;
                    end
                end

                // PRIME and SWITCH share the same "wait, then grant or go idle" exit.
                PRIME, SWITCH: begin
                    if (!lvl_ok) begin
                        state   <= FAULT;
                        pump_on <= 1'b0;
                        valve   <= '0;
                        err     <= 1'b1;
                        cnt     <= '0;
                    end else if ((state == PRIME  && cnt == PRIME_LAST) ||
                                 (state == SWITCH && cnt == DRAIN_LAST)) begin
                        cnt <= '0;
                        if (pick_found) begin
                            state   <= OPEN;
                            valve   <= N_VALVES'(1) << pick_idx;
                            gnt_idx <= pick_idx;
                        end else begin
                            state   <= IDLE;
                            pump_on <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                OPEN: begin
                    if (!lvl_ok) begin
                        state   <= FAULT;
                        pump_on <= 1'b0;
                        valve   <= '0;
                        err     <= 1'b1;
                        cnt     <= '0;
                    end else if (cnt == SLOT_LAST || !req[gnt_idx]) begin
                        state <= SWITCH;
                        valve <= '0;
                        done  <= N_VALVES'(1) << gnt_idx;
                        ptr   <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Requesters must withdraw before watering can resume.
                FAULT: begin
                    if (lvl_ok && req == '0) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    pump_on <= 1'b0;
                    valve   <= '0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule
